enemy_wave_scheduler: RTL and testbench
=======================================

// Module: enemy_wave_scheduler
// PURPOSE
//  Sequences enemy waves into the game core when its built-in spawner is disabled (AUTO_SPAWN=0).
//  Issues single-cycle enemy_spawn pulses with a pseudo-random column, paced by a per-wave interval.
//  Stalls while all three enemy slots are occupied, and ramps difficulty wave by wave.
//  Sits beside game_design and drives its enemy_spawn, enemy_init_x and enemy_init_y inputs.
// PARAMETERS
//  GRID_W         20     playfield columns; spawn x range is 0..GRID_W-1
//  SPAWN_Y        0      row given to every spawned enemy (4-bit)
//  BASE_INTERVAL  16     cycles between spawns in wave 1
//  INTERVAL_STEP  2      interval reduction per wave
//  MIN_INTERVAL   4      interval floor; must be >=2
//  BASE_COUNT     3      enemies in wave 1
//  MAX_COUNT      15     cap on enemies per wave (4-bit)
//  WAVE_GAP       32     idle cycles between wave_done and the next wave's first timer load
//  LFSR_SEED      5'h15  LFSR reset value; must be nonzero
// PORTS
//  clk            in   1  system clock
//  rst            in   1  synchronous, active-high reset
//  start          in   1  level; sampled in IDLE only, begins wave 1
//  pause          in   1  freezes the WAIT and GAP timers while high
//  enemy_active   in   3  {enemy2,enemy1,enemy0}_active from the game core
//  enemy_spawn    out  1  one-cycle spawn request
//  enemy_init_x   out  5  spawn column; held until the next spawn
//  enemy_init_y   out  4  spawn row; held until the next spawn
//  spawn_slot     out  2  lowest free slot index at spawn (informational)
//  wave           out  8  current wave number, 0 = not started; saturates at 255
//  remaining      out  4  spawns left in the current wave
//  wave_done      out  1  one-cycle pulse when a wave is fully spawned and cleared
//  busy           out  1  high in every state except IDLE
// BEHAVIOUR
//  Reset
//   - All outputs are 0; state = IDLE; timer = 0; lfsr = LFSR_SEED.
//   - Reset asserted in any state, including mid-SPAWN, returns to IDLE on the next edge. No further pulse is issued.
//  Wave formulas (w >= 1), computed at 9+ bits so they never underflow
//   - count(w)    = min(BASE_COUNT + w - 1, MAX_COUNT)
//   - interval(w) = max(BASE_INTERVAL - (w-1)*INTERVAL_STEP, MIN_INTERVAL)
//  FSM: IDLE -> WAIT -> SPAWN -> (WAIT | DRAIN) -> GAP -> WAIT ...
//   - IDLE: start=1 sets wave=1 and remaining=count(1), loads the timer, and moves to WAIT.
//     First enemy_spawn occurs exactly interval(1) cycles after the start-sample edge.
//   - WAIT: when the timer expires with a free slot (~&enemy_active), go to SPAWN.
//     Consecutive spawn pulses are exactly interval(wave) cycles apart, absent stall or pause.
//     Stall: timer expired but enemy_active==3'b111 -> hold in WAIT. Spawn the cycle after any slot frees.
//     Pause: while high, the timer holds and SPAWN is not entered. Each paused cycle delays the spawn by one cycle.
//   - SPAWN: enemy_spawn=1 for exactly one cycle. Registered enemy_init_x, enemy_init_y and spawn_slot are valid in that same cycle.
//     remaining decrements. If the new value is 0, go to DRAIN; otherwise reload the timer and go to WAIT.
//   - DRAIN: wait for enemy_active==3'b000. Then wave_done=1 for one cycle, timer=WAVE_GAP, go to GAP.
//   - GAP: count down WAVE_GAP, honouring pause. Then wave++ (saturating), remaining=count(wave), load the timer, go to WAIT.
//  Other rules
//   - start is ignored outside IDLE.
//   - busy is 0 only in IDLE.
//   - LFSR: 5-bit Fibonacci, x^5+x^3+1, advances every non-reset cycle.
//   - x = (lfsr >= GRID_W) ? lfsr - GRID_W : lfsr, giving a range of 0..19.
//   - enemy_init_y = SPAWN_Y.
//   - spawn_slot = lowest index i with enemy_active[i]==0.
// STRUCTURE
//  - game_pkg holds GRID_W=20, GRID_H=15, X_W=5, Y_W=4, NUM_ENEMIES=3, and the sched_state_t enum {IDLE,WAIT,SPAWN,DRAIN,GAP}.
//  - Sub-module spawn_lfsr: seedable LFSR plus mod-GRID_W fold. It outputs a 5-bit column.
//  - Top level holds the FSM, timer, wave/remaining counters and the formula logic.
// TESTING
//  Bench couples this block to game_design with AUTO_SPAWN=0, plus a unit bench with a forced enemy_active.
//  1. rst high for 2 cycles -> all outputs 0, busy=0, wave=0; internal lfsr==5'h15.
//  2. start sampled at cycle 10, enemy_active=0, defaults
//     -> spawns at 26, 42 and 58, each with x<=19 and y=0; remaining goes 3,2,1,0.
//     -> wave_done 1 cycle after DRAIN entry; wave=2 after the 32-cycle gap; 4 spawns 14 cycles apart.
//  3. enemy_active=3'b111 at timer expiry -> no pulse.
//     Clear bit1 at cycle k -> spawn at k+1 with spawn_slot=1.
//  4. pause high for 5 cycles mid-WAIT -> next spawn is 5 cycles later than nominal; pause in GAP stretches the gap by the same amount.
//  5. Run to wave 7 -> interval=4 (MIN), count=9.
//     Wave 13 -> count=15 (capped). Wave never wraps past 255.
//  6. rst asserted during a SPAWN cycle -> next cycle enemy_spawn=0, busy=0, wave=0.
//     start again -> first spawn interval(1) cycles later.

Source files
------------

// File: rtl/game_pkg.sv
// Shared playfield geometry and the wave scheduler state encoding.
package game_pkg;

   localparam int GRID_W      = 20;
   localparam int GRID_H      = 15;
   localparam int X_W         = 5;
   localparam int Y_W         = 4;
   localparam int NUM_ENEMIES = 3;

   typedef enum logic [2:0] {
      IDLE,
      WAIT,
      SPAWN,
      DRAIN,
      GAP
   } sched_state_t;

endpackage

// File: rtl/spawn_lfsr.sv
// Free-running 5-bit Fibonacci LFSR (x^5+x^3+1) folded into a playfield column.
module spawn_lfsr
   import game_pkg::*;
#(
   parameter logic [X_W-1:0] SEED = 5'h15,
   parameter int             COLS = 20
) (
   input  logic           clk,
   input  logic           rst,
   output logic [X_W-1:0] col
);

   logic [X_W-1:0] lfsr;

   always_ff @(posedge clk) begin
      if (rst) lfsr <= SEED;
      else     lfsr <= {lfsr[3:0], lfsr[4] ^ lfsr[2]};
   end

   // A nonzero 5-bit state is 1..31, so a single subtraction lands in 0..COLS-1.
   always_comb begin
      col = lfsr;
      if (lfsr >= X_W'(COLS)) col = lfsr - X_W'(COLS);
   end

endmodule

// File: rtl/enemy_wave_scheduler.sv
// Paces enemy spawn pulses into the game core wave by wave, with stall, pause and difficulty ramp.
module enemy_wave_scheduler
   import game_pkg::*;
#(
   parameter int             GRID_W        = 20,
   parameter int             SPAWN_Y       = 0,
   parameter int             BASE_INTERVAL = 16,
   parameter int             INTERVAL_STEP = 2,
   parameter int             MIN_INTERVAL  = 4,
   parameter int             BASE_COUNT    = 3,
   parameter int             MAX_COUNT     = 15,
   parameter int             WAVE_GAP      = 32,
   parameter logic [X_W-1:0] LFSR_SEED     = 5'h15
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   pause,
   input  logic [NUM_ENEMIES-1:0] enemy_active,
   output logic                   enemy_spawn,
   output logic [X_W-1:0]         enemy_init_x,
   output logic [Y_W-1:0]         enemy_init_y,
   output logic [1:0]             spawn_slot,
   output logic [7:0]             wave,
   output logic [3:0]             remaining,
   output logic                   wave_done,
   output logic                   busy
);

   localparam int TMR_MAX = (BASE_INTERVAL > WAVE_GAP) ? BASE_INTERVAL : WAVE_GAP;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);

   sched_state_t     state, state_nxt;
   logic [TMR_W-1:0] tmr;
   logic             start_go, spawn_go, done_go, gap_end, spawn_more;
   logic [7:0]       wave_inc, calc_wave;
   logic [TMR_W-1:0] ivl;
   logic [3:0]       cnt;
   logic [X_W-1:0]   col;
   logic [1:0]       free_slot;

   function automatic int count_of(input logic [7:0] w);
      int c;
      c = BASE_COUNT + int'(w) - 1;
      return (c > MAX_COUNT) ? MAX_COUNT : c;
   endfunction

   function automatic int interval_of(input logic [7:0] w);
      int i;
      i = BASE_INTERVAL - (int'(w) - 1) * INTERVAL_STEP;
      return (i < MIN_INTERVAL) ? MIN_INTERVAL : i;
   endfunction

   spawn_lfsr #(
      .SEED (LFSR_SEED),
      .COLS (GRID_W)
   ) u_lfsr (
      .clk (clk),
      .rst (rst),
      .col (col)
   );

   assign wave_inc  = (wave == 8'hFF) ? wave : wave + 8'd1;
   assign calc_wave = (state == IDLE) ? 8'd1 : (state == GAP) ? wave_inc : wave;
   assign cnt       = 4'(count_of(calc_wave));
   assign ivl       = TMR_W'(interval_of(calc_wave));
   assign busy      = (state != IDLE);

   always_comb begin
      free_slot = 2'd0;
      if      (!enemy_active[0]) free_slot = 2'd0;
      else if (!enemy_active[1]) free_slot = 2'd1;
      else if (!enemy_active[2]) free_slot = 2'd2;
   end

   always_comb begin
      state_nxt  = state;
      start_go   = 1'b0;
      spawn_go   = 1'b0;
      done_go    = 1'b0;
      gap_end    = 1'b0;
      spawn_more = 1'b0;
      case (state)
         IDLE: if (start) begin
            start_go  = 1'b1;
            state_nxt = WAIT;
         end
         WAIT: if (!pause && tmr == '0 && !(&enemy_active)) begin
            spawn_go  = 1'b1;
            state_nxt = SPAWN;
         end
         SPAWN: begin
            spawn_more = (remaining != 4'd1);
            state_nxt  = spawn_more ? WAIT : DRAIN;
         end
         DRAIN: if (enemy_active == '0) begin
            done_go   = 1'b1;
            state_nxt = GAP;
         end
         GAP: if (!pause && tmr == '0) begin
            gap_end   = 1'b1;
            state_nxt = WAIT;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Loads are one less than the interval from IDLE/GAP and two less from SPAWN, so the
   // pulse lands exactly interval cycles after the start/gap-exit edge or the previous pulse.
   always_ff @(posedge clk) begin
      if (rst)                    tmr <= '0;
      else if (start_go)          tmr <= ivl - TMR_W'(1);
      else if (spawn_more)        tmr <= ivl - TMR_W'(2);
      else if (done_go)           tmr <= TMR_W'(WAVE_GAP);
      else if (gap_end)           tmr <= ivl - TMR_W'(1);
      else if ((state == WAIT || state == GAP) && !pause && tmr != '0)
                                  tmr <= tmr - TMR_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wave      <= '0;
         remaining <= '0;
      end else if (start_go) begin
         wave      <= 8'd1;
         remaining <= cnt;
      end else if (gap_end) begin
         wave      <= wave_inc;
         remaining <= cnt;
      end else if (state == SPAWN) begin
         remaining <= remaining - 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         enemy_spawn  <= 1'b0;
         enemy_init_x <= '0;
         enemy_init_y <= '0;
         spawn_slot   <= '0;
         wave_done    <= 1'b0;
      end else begin
         enemy_spawn <= spawn_go;
         wave_done   <= done_go;
         if (spawn_go) begin
            enemy_init_x <= col;
            enemy_init_y <= Y_W'(SPAWN_Y);
            spawn_slot   <= free_slot;
         end
      end
   end

endmodule

// File: tb/tb_enemy_wave_scheduler.sv
// Directed bench for enemy_wave_scheduler with a forced enemy_active vector.
module tb_enemy_wave_scheduler;

   logic       clk = 1'b0;
   logic       rst, start, pause;
   logic [2:0] enemy_active;
   logic       enemy_spawn, wave_done, busy;
   logic [4:0] enemy_init_x;
   logic [3:0] enemy_init_y;
   logic [1:0] spawn_slot;
   logic [7:0] wave;
   logic [3:0] remaining;

   int n_assert = 0;
   int n_fail   = 0;

   logic [4:0] m_lfsr = 5'h15;
   logic [4:0] m_prev = 5'h0;

   int cnt_t [4:13] = '{6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
   int ivl_t [4:13] = '{10, 8, 6, 4, 4, 4, 4, 4, 4, 4};

   enemy_wave_scheduler #(
      .GRID_W        (20),
      .SPAWN_Y       (0),
      .BASE_INTERVAL (16),
      .INTERVAL_STEP (2),
      .MIN_INTERVAL  (4),
      .BASE_COUNT    (3),
      .MAX_COUNT     (15),
      .WAVE_GAP      (32),
      .LFSR_SEED     (5'h15)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .pause        (pause),
      .enemy_active (enemy_active),
      .enemy_spawn  (enemy_spawn),
      .enemy_init_x (enemy_init_x),
      .enemy_init_y (enemy_init_y),
      .spawn_slot   (spawn_slot),
      .wave         (wave),
      .remaining    (remaining),
      .wave_done    (wave_done),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   // Reference LFSR: x^5+x^3+1, stepping on every non-reset edge.
   always @(posedge clk) begin
      if (rst) m_lfsr <= 5'h15;
      else begin
         m_prev <= m_lfsr;
         m_lfsr <= {m_lfsr[3:0], m_lfsr[4] ^ m_lfsr[2]};
      end
   end

   function automatic logic [4:0] fold(input logic [4:0] v);
      return (v >= 5'd20) ? v - 5'd20 : v;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_spawn(input int budget, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (enemy_spawn !== 1'b1 && n < budget);
      chk("spawn_seen", {31'd0, enemy_spawn}, 32'd1);
      if (enemy_spawn === 1'b1) begin
         chk("spawn_x", {27'd0, enemy_init_x}, {27'd0, fold(m_prev)});
         chk("spawn_x_range", {31'd0, enemy_init_x <= 5'd19}, 32'd1);
         chk("spawn_y", {28'd0, enemy_init_y}, 32'd0);
      end
   endtask

   task automatic wait_done(input int budget, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (wave_done !== 1'b1 && n < budget);
      chk("wave_done_seen", {31'd0, wave_done}, 32'd1);
   endtask

   task automatic run_wave(input int w, input int cnt, input int ivl, input int first);
      int n;
      for (int i = 0; i < cnt; i++) begin
         wait_spawn(400, n);
         chk($sformatf("w%0d_spawn%0d_lat", w, i), n, (i == 0) ? first : ivl);
         chk($sformatf("w%0d_wave", w), {24'd0, wave}, w);
         chk($sformatf("w%0d_rem%0d", w, i), {28'd0, remaining}, cnt - i);
      end
      wait_done(400, n);
      chk($sformatf("w%0d_done_lat", w), n, 2);
      chk($sformatf("w%0d_rem_end", w), {28'd0, remaining}, 0);
   endtask

   initial begin
      int n, spawns;
      rst = 1'b1; start = 1'b0; pause = 1'b0; enemy_active = 3'b000;
      tick(); tick();
      chk("rst_spawn", {31'd0, enemy_spawn}, 0);
      chk("rst_x", {27'd0, enemy_init_x}, 0);
      chk("rst_y", {28'd0, enemy_init_y}, 0);
      chk("rst_slot", {30'd0, spawn_slot}, 0);
      chk("rst_wave", {24'd0, wave}, 0);
      chk("rst_rem", {28'd0, remaining}, 0);
      chk("rst_done", {31'd0, wave_done}, 0);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_lfsr", {27'd0, dut.u_lfsr.lfsr}, 32'h15);
      rst = 1'b0;
      for (int i = 0; i < 7; i++) tick();
      chk("idle_busy", {31'd0, busy}, 0);

      // wave 1, start held high throughout to show it is ignored outside IDLE
      start = 1'b1;
      tick();
      chk("start_busy", {31'd0, busy}, 1);
      chk("start_wave", {24'd0, wave}, 1);
      run_wave(1, 3, 16, 16);
      start = 1'b0;

      // wave 2: stall, slot selection and pause in WAIT
      wait_spawn(400, n);
      chk("w2_first_lat", n, 47);
      chk("w2_wave", {24'd0, wave}, 2);
      chk("w2_rem0", {28'd0, remaining}, 4);
      enemy_active = 3'b111;
      spawns = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (enemy_spawn === 1'b1) spawns++;
      end
      chk("stall_no_spawn", spawns, 0);
      chk("stall_busy", {31'd0, busy}, 1);
      enemy_active = 3'b101;
      wait_spawn(400, n);
      chk("stall_release_lat", n, 1);
      chk("stall_slot", {30'd0, spawn_slot}, 1);
      chk("w2_rem1", {28'd0, remaining}, 3);
      enemy_active = 3'b011;
      for (int i = 0; i < 3; i++) tick();
      pause = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      pause = 1'b0;
      wait_spawn(400, n);
      chk("pause_wait_lat", n, 11);
      chk("slot2", {30'd0, spawn_slot}, 2);
      chk("w2_rem2", {28'd0, remaining}, 2);
      enemy_active = 3'b110;
      wait_spawn(400, n);
      chk("w2_spawn3_lat", n, 14);
      chk("slot0", {30'd0, spawn_slot}, 0);
      chk("w2_rem3", {28'd0, remaining}, 1);
      enemy_active = 3'b000;
      wait_done(400, n);
      chk("w2_done_lat", n, 2);
      chk("w2_rem_end", {28'd0, remaining}, 0);
      tick();
      chk("done_one_cycle", {31'd0, wave_done}, 0);
      for (int i = 0; i < 9; i++) tick();
      pause = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      pause = 1'b0;

      // wave 3 first spawn: 10 + 5 paused + 35 = 33 + 12 + 5 after wave_done
      run_wave(3, 5, 12, 35);
      for (int w = 4; w <= 13; w++) run_wave(w, cnt_t[w], ivl_t[w], 33 + ivl_t[w]);

      for (int w = 14; w <= 255; w++) wait_done(400, n);
      chk("w255_reached", {24'd0, wave}, 255);
      run_wave(255, 15, 4, 37);

      // reset during a SPAWN cycle
      wait_spawn(400, n);
      chk("wsat_lat", n, 37);
      chk("wsat_wave", {24'd0, wave}, 255);
      rst = 1'b1;
      tick();
      chk("midrst_spawn", {31'd0, enemy_spawn}, 0);
      chk("midrst_busy", {31'd0, busy}, 0);
      chk("midrst_wave", {24'd0, wave}, 0);
      chk("midrst_rem", {28'd0, remaining}, 0);
      chk("midrst_x", {27'd0, enemy_init_x}, 0);
      chk("midrst_lfsr", {27'd0, dut.u_lfsr.lfsr}, 32'h15);
      rst = 1'b0;
      tick();
      chk("midrst_idle", {31'd0, busy}, 0);
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_spawn(400, n);
      chk("restart_lat", n, 16);
      chk("restart_wave", {24'd0, wave}, 1);
      chk("restart_rem", {28'd0, remaining}, 3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
